// File: rtl/boot_load_ctrl.sv
// boot_load_ctrl: owns RAM port 1 at power-up. Optionally receives a program
// over a UART byte stream (A5, LEN_LO, LEN_HI, N*4 data bytes, CSUM), writes it
// from word 0 upward while holding the core in reset, then releases the core
// and passes its data-port signals straight through to the RAM.
//
// Ports:
//   clk, n_rst          clock, async active-low reset
//   boot_en             1 = wait for a download, 0 = run immediately
//   rx_valid, rx_data   received byte strobe / byte
//   cpu_n_rst           registered active-low reset to the core
//   cpu_addr/wen/wbe/wdata  core data port (byte address)
//   mem_addr/wen/wbe/wdata  RAM port 1 (word address)
//   done, err           sticky load-complete / load-error flags
module boot_load_ctrl #(
  parameter int unsigned AWIDTH      = 12,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              boot_en,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              cpu_n_rst,
  input  logic [31:0]       cpu_addr,
  input  logic              cpu_wen,
  input  logic [3:0]        cpu_wbe,
  input  logic [31:0]       cpu_wdata,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_wen,
  output logic [3:0]        mem_wbe,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              err
);

  localparam int unsigned IW = AWIDTH + 1;                  // word index, holds 2^AWIDTH
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);     // idle counter
  localparam int unsigned LW = (IW > 17) ? IW : 17;         // common compare width
  localparam logic [7:0]    HDR_BYTE  = 8'hA5;
  localparam logic [LW-1:0] MAX_WORDS = LW'(1) << AWIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_RUN, S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic              cpu_n_rst_q, cpu_n_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              wr_en_q, wr_en_d;
  logic [3:0]        wr_wbe_q, wr_wbe_d;
  logic [AWIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [15:0]       len_q, len_d;
  logic [IW-1:0]     word_idx_q, word_idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       buf_q, buf_d;
  logic [7:0]        csum_q, csum_d;
  logic [TW-1:0]     idle_q, idle_d;

  logic [15:0] new_len;
  logic        counting;
  logic        timeout_hit;

  assign new_len     = {rx_data, len_q[7:0]};
  assign counting    = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                       (state_q == S_DATA) || (state_q == S_CSUM);
  assign timeout_hit = counting && !rx_valid && (idle_q == TW'(TIMEOUT_CYC - 1));

  // State register and loader datapath flops
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      cpu_n_rst_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_wbe_q    <= 4'h0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      len_q       <= '0;
      word_idx_q  <= '0;
      byte_cnt_q  <= '0;
      buf_q       <= '0;
      csum_q      <= '0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      cpu_n_rst_q <= cpu_n_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
      wr_en_q     <= wr_en_d;
      wr_wbe_q    <= wr_wbe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      buf_q       <= buf_d;
      csum_q      <= csum_d;
      idle_q      <= idle_d;
    end
  end

  // Next-state and loader datapath
  always_comb begin
    state_d     = state_q;
    cpu_n_rst_d = (state_q == S_RUN);   // core leaves reset the cycle after RUN entry
    done_d      = done_q;
    err_d       = err_q;
    wr_en_d     = 1'b0;                 // write pulse lasts exactly one cycle
    wr_wbe_d    = 4'h0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    len_d       = len_q;
    word_idx_d  = word_idx_q;
    byte_cnt_d  = byte_cnt_q;
    buf_d       = buf_q;
    csum_d      = csum_q;
    idle_d      = '0;

    if (counting) begin
      idle_d = rx_valid ? '0 : idle_q + TW'(1);
    end

    case (state_q)
      S_IDLE: state_d = boot_en ? S_HDR : S_RUN;
      S_HDR: begin
        if (rx_valid && (rx_data == HDR_BYTE)) state_d = S_LEN0;
      end
      S_LEN0: begin
        if (rx_valid) begin
          len_d   = {8'h00, rx_data};
          state_d = S_LEN1;
        end
      end
      S_LEN1: begin
        if (rx_valid) begin
          len_d = new_len;
          if (LW'(new_len) > MAX_WORDS) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (new_len == 16'h0000) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          csum_d     = csum_q + rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: buf_d[7:0]   = rx_data;
            2'd1: buf_d[15:8]  = rx_data;
            2'd2: buf_d[23:16] = rx_data;
            default: begin
              // Fourth byte completes the word; it goes straight into the write register
              wr_en_d    = 1'b1;
              wr_wbe_d   = 4'hF;
              wr_addr_d  = word_idx_q[AWIDTH-1:0];
              wr_data_d  = {rx_data, buf_q};
              word_idx_d = word_idx_q + IW'(1);
              if ((LW'(word_idx_q) + LW'(1)) == LW'(len_q)) state_d = S_CSUM;
            end
          endcase
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_data == csum_q) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: ;  // RUN and ERR are terminal
    endcase

    // Stalled frame: resync on a fresh header, already-written words stay in RAM
    if (timeout_hit) begin
      state_d    = S_HDR;
      word_idx_d = '0;
      byte_cnt_d = '0;
      csum_d     = '0;
      idle_d     = '0;
    end
  end

  // Port-1 mux: core pass-through only once running
  logic run;
  assign run       = (state_q == S_RUN);
  assign mem_addr  = run ? cpu_addr[AWIDTH+1:2] : wr_addr_q;
  assign mem_wen   = run ? cpu_wen : wr_en_q;
  assign mem_wbe   = run ? cpu_wbe : wr_wbe_q;
  assign mem_wdata = run ? cpu_wdata : wr_data_q;

  assign cpu_n_rst = cpu_n_rst_q;
  assign done      = done_q;
  assign err       = err_q;

  // Address bits outside the RAM word range are intentionally dropped
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:AWIDTH+2], cpu_addr[1:0]};

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Directed bench for boot_load_ctrl with a write scoreboard: expected RAM
// writes are queued as frames are sent and popped by a monitor on mem_wen.
module tb_boot_load_ctrl;
  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          boot_en;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          cpu_n_rst;
  logic [31:0]   cpu_addr;
  logic          cpu_wen;
  logic [3:0]    cpu_wbe;
  logic [31:0]   cpu_wdata;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [3:0]    mem_wbe;
  logic [31:0]   mem_wdata;
  logic          done;
  logic          err;

  boot_load_ctrl #(.AWIDTH(AW), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .n_rst(n_rst), .boot_en(boot_en),
    .rx_valid(rx_valid), .rx_data(rx_data), .cpu_n_rst(cpu_n_rst),
    .cpu_addr(cpu_addr), .cpu_wen(cpu_wen), .cpu_wbe(cpu_wbe), .cpu_wdata(cpu_wdata),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wbe(mem_wbe), .mem_wdata(mem_wdata),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  bit  mon_en = 1'b0;
  int  checks = 0;
  int  failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every loader write must match the head of the queue
  always @(negedge clk) begin
    if (mon_en && n_rst === 1'b1 && mem_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(mem_wen), 32'h0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(w.addr));
        check("wr_data", mem_wdata, w.data);
        check("wr_wbe", 32'(mem_wbe), 32'hF);
      end
    end
  end

  // Called at a negedge; byte is taken on the following posedge
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] bs[$]);
    foreach (bs[i]) send(bs[i]);
  endtask

  // Ends at the negedge where n_rst is released
  task automatic do_reset(input logic boot);
    @(negedge clk);
    n_rst    = 1'b0;
    rx_valid = 1'b0;
    cpu_wen  = 1'b0;
    boot_en  = boot;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  initial begin
    logic [7:0]  f[$];
    logic [7:0]  b;
    logic [7:0]  cs;
    logic [31:0] w;

    n_rst     = 1'b0;
    boot_en   = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    cpu_wen   = 1'b1;
    cpu_addr  = 32'h0000_FFFC;
    cpu_wbe   = 4'hF;
    cpu_wdata = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);

    // Reset values; core signals must not leak through
    check("rst_cpu_n_rst", 32'(cpu_n_rst), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_mem_wen", 32'(mem_wen), 32'h0);
    check("rst_mem_wbe", 32'(mem_wbe), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);

    // boot_en=0: straight to RUN, core released two cycles after reset
    cpu_wen = 1'b0;
    n_rst   = 1'b1;
    @(negedge clk);
    check("run_cpu_n_rst_c1", 32'(cpu_n_rst), 32'h0);
    @(negedge clk);
    check("run_cpu_n_rst_c2", 32'(cpu_n_rst), 32'h1);
    cpu_wen   = 1'b1;
    cpu_addr  = 32'h10;
    cpu_wdata = 32'h1234_5678;
    cpu_wbe   = 4'h3;
    #1;
    check("pt_addr", 32'(mem_addr), 32'h4);
    check("pt_wen", 32'(mem_wen), 32'h1);
    check("pt_wbe", 32'(mem_wbe), 32'h3);
    check("pt_wdata", mem_wdata, 32'h1234_5678);
    check("pt_done", 32'(done), 32'h0);
    cpu_wen = 1'b0;

    // Good two-word load; data-byte checksum is 0x4C
    do_reset(1'b1);
    mon_en = 1'b1;
    @(negedge clk);
    push_wr(12'd0, 32'h1234_5678);
    push_wr(12'd1, 32'hDEAD_BEEF);
    f = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
    send_bytes(f);
    check("ok_done", 32'(done), 32'h1);
    check("ok_err", 32'(err), 32'h0);
    check("ok_cpu_n_rst_c0", 32'(cpu_n_rst), 32'h0);
    @(negedge clk);
    check("ok_cpu_n_rst_c1", 32'(cpu_n_rst), 32'h1);
    check("ok_writes_left", 32'(exp_q.size()), 32'h0);

    // Bad checksum: words still written, then ERR blocks the core port
    do_reset(1'b1);
    @(negedge clk);
    push_wr(12'd0, 32'h1234_5678);
    push_wr(12'd1, 32'hDEAD_BEEF);
    f = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4F};
    send_bytes(f);
    check("bad_err", 32'(err), 32'h1);
    check("bad_done", 32'(done), 32'h0);
    for (int i = 0; i < 4; i++) begin
      cpu_wen  = 1'b1;
      cpu_addr = 32'(i * 4);
      #1;
      check("bad_no_wen", 32'(mem_wen), 32'h0);
      @(negedge clk);
      cpu_wen = 1'b0;
    end
    check("bad_cpu_n_rst", 32'(cpu_n_rst), 32'h0);
    check("bad_writes_left", 32'(exp_q.size()), 32'h0);

    // Garbage before header, zero-length frame
    do_reset(1'b1);
    @(negedge clk);
    f = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_bytes(f);
    check("zero_done", 32'(done), 32'h1);
    check("zero_err", 32'(err), 32'h0);

    // Length 0x1001 exceeds 4096 words: error on the LEN_HI byte
    do_reset(1'b1);
    @(negedge clk);
    f = {8'hA5, 8'h01, 8'h10};
    send_bytes(f);
    check("len_err", 32'(err), 32'h1);
    check("len_done", 32'(done), 32'h0);

    // Stalled frame times out after 16 idle cycles, then a clean reload
    do_reset(1'b1);
    @(negedge clk);
    f = {8'hA5, 8'h01, 8'h00, 8'h11};
    send_bytes(f);
    repeat (16) @(negedge clk);
    check("to_err", 32'(err), 32'h0);
    push_wr(12'd0, 32'h4433_2211);
    f = {8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    send_bytes(f);
    check("to_done", 32'(done), 32'h1);
    check("to_err2", 32'(err), 32'h0);
    check("to_writes_left", 32'(exp_q.size()), 32'h0);

    // Back-to-back 3-word frame with random data
    do_reset(1'b1);
    @(negedge clk);
    f  = {8'hA5, 8'h03, 8'h00};
    cs = 8'h00;
    w  = 32'h0;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      f.push_back(b);
      cs = cs + b;
      w  = {b, w[31:8]};
      if ((i % 4) == 3) push_wr(AW'(i / 4), w);
    end
    f.push_back(cs);
    send_bytes(f);
    check("b2b_done", 32'(done), 32'h1);
    check("b2b_writes_left", 32'(exp_q.size()), 32'h0);

    // Reset while a write pulse is live
    do_reset(1'b1);
    @(negedge clk);
    push_wr(12'd0, 32'h0403_0201);
    f = {8'hA5, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_bytes(f);
    #2;
    check("mid_pulse_live", 32'(mem_wen), 32'h1);
    n_rst = 1'b0;
    #1;
    check("mid_mem_wen", 32'(mem_wen), 32'h0);
    check("mid_mem_addr", 32'(mem_addr), 32'h0);
    check("mid_mem_wdata", mem_wdata, 32'h0);
    check("mid_mem_wbe", 32'(mem_wbe), 32'h0);
    check("mid_cpu_n_rst", 32'(cpu_n_rst), 32'h0);
    check("mid_done", 32'(done), 32'h0);
    check("mid_err", 32'(err), 32'h0);
    check("mid_writes_left", 32'(exp_q.size()), 32'h0);
    mon_en = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
